// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: round-robin burst scheduler for two PRBS consumers.
// A 6-bit XNOR LFSR (x^6 + x^5 + 1) supplies the words. It advances only on
// accepted words, so the sequence is shared across requesters with no gaps.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; honours seed_ld first, then arbitrates on req
// BURST | one requester granted; words stream on valid/ready until last
module lfsr_burst_ctrl #(
  parameter logic [5:0] SEED = 6'b000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic [3:0] i_len0,
  input  logic [3:0] i_len1,
  input  logic       i_seed_ld,
  input  logic [5:0] i_seed,
  input  logic       i_ready,
  output logic [1:0] o_gnt,
  output logic       o_valid,
  output logic [5:0] o_y,
  output logic       o_last,
  output logic       o_busy
);

  // The all-ones word is the XNOR lock-up state, so it is never loaded.
  localparam logic [5:0] SEED_EFF = (SEED == 6'h3F) ? 6'h00 : SEED;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_lfsr;
  logic [5:0] w_lfsr_nxt;
  logic [4:0] r_count;
  logic [4:0] w_count_nxt;
  logic       r_rr;
  logic       w_rr_nxt;
  logic [1:0] r_gnt;
  logic [1:0] w_gnt_nxt;
  logic       r_valid;
  logic       w_valid_nxt;

  logic       w_last;
  logic       w_xfer;
  logic       w_winner;
  logic [3:0] w_len_sel;
  logic [5:0] w_lfsr_step;

  // Combinational helpers: last flag, transfer strobe, LFSR successor, arbiter.
  always_comb begin
    w_last      = r_valid & (r_count == 5'd1);
    w_xfer      = r_valid & i_ready;
    // y = ff[6:1]; shift toward ff[6], new ff[1] = ff[5] xnor ff[6].
    w_lfsr_step = {r_lfsr[4:0], ~(r_lfsr[4] ^ r_lfsr[5])};
    w_winner    = i_req[r_rr] ? r_rr : ~r_rr;
    w_len_sel   = w_winner ? i_len1 : i_len0;
  end

  // Next-state and next-register values; defaults hold every register.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_count_nxt = r_count;
    w_rr_nxt    = r_rr;
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (i_seed_ld) begin
          w_lfsr_nxt = (i_seed == 6'h3F) ? 6'h00 : i_seed;
        end else if (i_req != 2'b00) begin
          w_gnt_nxt   = w_winner ? 2'b10 : 2'b01;
          w_valid_nxt = 1'b1;
          w_count_nxt = (w_len_sel == 4'd0) ? 5'd16 : {1'b0, w_len_sel};
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (w_xfer) begin
          w_lfsr_nxt  = w_lfsr_step;
          w_count_nxt = r_count - 5'd1;
          if (w_last) begin
            w_gnt_nxt   = 2'b00;
            w_valid_nxt = 1'b0;
            // r_gnt is one-hot here, so bit 1 identifies the winner.
            w_rr_nxt    = ~r_gnt[1];
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 2'b00;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_lfsr  <= SEED_EFF;
      r_count <= 5'd0;
      r_rr    <= 1'b0;
      r_gnt   <= 2'b00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_count <= w_count_nxt;
      r_rr    <= w_rr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    o_gnt   = r_gnt;
    o_valid = r_valid;
    o_y     = r_lfsr;
    o_last  = w_last;
    o_busy  = (r_state == BURST);
  end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Directed testbench for lfsr_burst_ctrl with hand-computed expectations.
module tb_lfsr_burst_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       seed_ld;
  logic [5:0] seed;
  logic       ready;
  logic [1:0] gnt;
  logic       valid;
  logic [5:0] y;
  logic       last;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer;

  // LFSR states from 00, worked out by hand (new bit = y[4] xnor y[5]).
  logic [5:0] seq [0:18] = '{6'h00, 6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E,
                             6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39,
                             6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A};

  lfsr_burst_ctrl #(.SEED(6'h00)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_req     (req),
    .i_len0    (len0),
    .i_len1    (len1),
    .i_seed_ld (seed_ld),
    .i_seed    (seed),
    .i_ready   (ready),
    .o_gnt     (gnt),
    .o_valid   (valid),
    .o_y       (y),
    .o_last    (last),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
    seed_ld = 1'b0; seed = 6'h00; ready = 1'b0;
    #2;

    // Reset and first burst
    do_reset();
    chk("rst_gnt",   gnt,   2'b00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_last",  last,  1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_y",     y,     6'h00);
    req = 2'b01; len0 = 4'd4; ready = 1'b1;
    tick();
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("b1_gnt",  gnt,   2'b01);
      chk("b1_busy", busy,  1'b1);
      chk("b1_y",    y,     seq[i]);
      chk("b1_last", last,  (i == 3));
      tick();
    end
    chk("b1_end_gnt",   gnt,   2'b00);
    chk("b1_end_valid", valid, 1'b0);
    chk("b1_end_y",     y,     6'h0F);

    // Backpressure
    do_reset();
    req = 2'b01; len0 = 4'd3;
    tick();
    req = 2'b00;
    begin
      logic [5:0] bp_y [0:4] = '{6'h00, 6'h01, 6'h01, 6'h01, 6'h03};
      logic       bp_r [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      n_xfer = 0;
      for (int i = 0; i < 5; i++) begin
        ready = bp_r[i];
        #1;
        chk("bp_y",    y,    bp_y[i]);
        chk("bp_last", last, (i == 4));
        if (valid && ready) n_xfer++;
        tick();
      end
    end
    chk("bp_xfers", n_xfer, 3);
    chk("bp_valid", valid,  1'b0);
    ready = 1'b1;

    // Round-robin with both requests held
    do_reset();
    req = 2'b11; len0 = 4'd2; len1 = 4'd2;
    tick();
    begin
      logic [1:0] rr_g [0:6] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
      logic [5:0] rr_y [0:6] = '{6'h00, 6'h01, 6'h03, 6'h03, 6'h07, 6'h0F, 6'h0F};
      for (int i = 0; i < 7; i++) begin
        chk("rr_gnt", gnt, rr_g[i]);
        chk("rr_y",   y,   rr_y[i]);
        tick();
      end
    end
    req = 2'b00;
    chk("rr_tail_y",    y,    6'h1F);
    chk("rr_tail_last", last, 1'b1);
    tick();
    chk("rr_tail_gnt", gnt, 2'b00);

    // len = 0 means 16 words
    do_reset();
    req = 2'b10; len1 = 4'd0;
    tick();
    req = 2'b00;
    n_xfer = 0;
    for (int i = 0; i < 16; i++) begin
      chk("l16_gnt",  gnt,  2'b10);
      chk("l16_y",    y,    seq[i]);
      chk("l16_last", last, (i == 15));
      if (valid && ready) n_xfer++;
      tick();
    end
    chk("l16_xfers", n_xfer, 16);
    chk("l16_valid", valid,  1'b0);
    chk("l16_y_end", y,      6'h0E);
    req = 2'b11; len0 = 4'd1;
    tick();
    req = 2'b00;
    chk("l16_rr_next", gnt, 2'b01);
    chk("l16_one_last", last, 1'b1);
    tick();

    // Seed handling
    do_reset();
    seed_ld = 1'b1; seed = 6'h2A; req = 2'b01; len0 = 4'd2;
    tick();
    seed_ld = 1'b0;
    chk("sd_y",      y,   6'h2A);
    chk("sd_no_gnt", gnt, 2'b00);
    tick();
    req = 2'b00;
    chk("sd_gnt",   gnt, 2'b01);
    chk("sd_word0", y,   6'h2A);
    seed_ld = 1'b1; seed = 6'h15;
    tick();
    chk("sd_mid_y",    y,    6'h14);
    chk("sd_mid_last", last, 1'b1);
    seed_ld = 1'b0;
    tick();
    chk("sd_end_gnt", gnt, 2'b00);
    chk("sd_end_y",   y,   6'h28);
    seed_ld = 1'b1; seed = 6'h3F;
    tick();
    seed_ld = 1'b0;
    chk("sd_3f_y", y, 6'h00);

    // Reset mid-burst
    do_reset();
    req = 2'b10; len1 = 4'd8;
    tick();
    chk("rm_w0", y, 6'h00);
    tick();
    chk("rm_w1", y, 6'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_gnt",   gnt,   2'b00);
    chk("rm_valid", valid, 1'b0);
    chk("rm_last",  last,  1'b0);
    chk("rm_busy",  busy,  1'b0);
    chk("rm_y",     y,     6'h00);
    tick();
    chk("rm_regnt", gnt, 2'b10);
    chk("rm_rey",   y,   6'h00);
    req = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
